// File: rtl/top_core_arb_if.sv
// ---------------------------------------------------------------------------
// top_core_arb_if
// Groups the requester-side and core-side handshake of the round-robin
// arbiter top_core_arb into one bundle. Signal names carry the direction as
// seen from the arbiter.
//   req_valid_i  [req_num_p]          per-requester data valid
//   req_data_i   [req_num_p*width_p]  requester n data at [n*width_p +: width_p]
//   req_ready_o  [req_num_p]          per-requester accept
//   core_valid_o / core_data_o        data towards the core
//   core_ready_i                      core accepts data
//   grant_o      [req_num_p]          one-hot current owner, zero when idle
//   busy_o                            high while a grant is held
// modport master : the arbiter side
// modport slave  : the requesters + core side (environment)
// ---------------------------------------------------------------------------
interface top_core_arb_if #(
   parameter int width_p   = 8,
   parameter int req_num_p = 4
);
   logic [req_num_p-1:0]         req_valid_i;
   logic [req_num_p*width_p-1:0] req_data_i;
   logic [req_num_p-1:0]         req_ready_o;
   logic                         core_valid_o;
   logic [width_p-1:0]           core_data_o;
   logic                         core_ready_i;
   logic [req_num_p-1:0]         grant_o;
   logic                         busy_o;

   modport master (
      input  req_valid_i,
      input  req_data_i,
      input  core_ready_i,
      output req_ready_o,
      output core_valid_o,
      output core_data_o,
      output grant_o,
      output busy_o
   );

   modport slave (
      output req_valid_i,
      output req_data_i,
      output core_ready_i,
      input  req_ready_o,
      input  core_valid_o,
      input  core_data_o,
      input  grant_o,
      input  busy_o
   );
endinterface

// File: rtl/top_core_arb.sv
// ---------------------------------------------------------------------------
// top_core_arb
// Round-robin arbiter that hands a single core data port to one of req_num_p
// requesters for bursts of up to burst_p transfers. Two-state FSM:
//   IDLE  : pick the first valid requester at or after ptr (wrapping), grant
//           it on the next edge.
//   GRANT : the owner's valid/data are routed to the core and the core's
//           ready back to the owner. Leaves at the next edge after the last
//           burst transfer, or as soon as the owner drops valid.
// Ports:
//   main_clk_i  clock, all state on rising edge
//   main_rst_i  synchronous active-high reset
//   bus         top_core_arb_if.master (requester + core handshake, grant, busy)
// ---------------------------------------------------------------------------
module top_core_arb #(
   parameter int width_p   = 8,
   parameter int req_num_p = 4,
   parameter int burst_p   = 4
) (
   input logic            main_clk_i,
   input logic            main_rst_i,
   top_core_arb_if.master bus
);

   localparam int idx_w_lp = (req_num_p > 1) ? $clog2(req_num_p) : 1;
   localparam int cnt_w_lp = $clog2(burst_p + 1);
   localparam logic [idx_w_lp-1:0] idx_last_lp = idx_w_lp'(req_num_p - 1);
   localparam logic [idx_w_lp:0]   idx_num_lp  = (idx_w_lp + 1)'(req_num_p);
   localparam logic [cnt_w_lp-1:0] cnt_last_lp = cnt_w_lp'(burst_p - 1);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_e;

   state_e                 state_q;
   logic [idx_w_lp-1:0]    gidx_q;
   logic [idx_w_lp-1:0]    ptr_q;
   logic [cnt_w_lp-1:0]    cnt_q;
   logic [req_num_p-1:0]   grant_q;
   logic                   busy_q;

   logic                   found_s;
   logic [idx_w_lp-1:0]    sel_idx_s;
   logic [req_num_p-1:0]   sel_onehot_s;
   logic                   core_valid_s;
   logic [width_p-1:0]     core_data_s;
   logic [req_num_p-1:0]   req_ready_s;
   logic                   xfer_s;
   logic                   exit_s;
   logic [idx_w_lp-1:0]    ptr_d;

   // Round-robin search: first valid requester at ptr, ptr+1, ... with wrap.
   always_comb begin
      logic [idx_w_lp:0] sum_v;
      logic [idx_w_lp-1:0] idx_v;
      found_s      = 1'b0;
      sel_idx_s    = '0;
      sel_onehot_s = '0;
      sum_v        = '0;
      idx_v        = '0;
      for (int k = 0; k < req_num_p; k++) begin
         sum_v = {1'b0, ptr_q} + (idx_w_lp + 1)'(k);
         // Explicit compare-and-subtract so non-power-of-two counts wrap right.
         if (sum_v >= idx_num_lp) begin
            sum_v = sum_v - idx_num_lp;
         end else begin
            sum_v = sum_v;
         end
         idx_v = sum_v[idx_w_lp-1:0];
         if (!found_s && bus.req_valid_i[idx_v]) begin
            found_s   = 1'b1;
            sel_idx_s = idx_v;
         end else begin
            found_s   = found_s;
         end
      end
      for (int n = 0; n < req_num_p; n++) begin
         sel_onehot_s[n] = (sel_idx_s == idx_w_lp'(n));
      end
   end

   // Owner mux: route the owner's valid/data to the core, core ready back.
   always_comb begin
      core_valid_s = 1'b0;
      core_data_s  = '0;
      req_ready_s  = '0;
      for (int n = 0; n < req_num_p; n++) begin
         if ((state_q == ST_GRANT) && (gidx_q == idx_w_lp'(n))) begin
            core_valid_s   = bus.req_valid_i[n];
            core_data_s    = bus.req_data_i[n*width_p +: width_p];
            req_ready_s[n] = bus.core_ready_i;
         end else begin
            req_ready_s[n] = 1'b0;
         end
      end
   end

   // Transfer / exit qualification and the pointer value used on exit.
   always_comb begin
      xfer_s = core_valid_s & bus.core_ready_i;
      // Owner dropping valid exits immediately; otherwise only the last
      // burst transfer ends the grant, so a stall never forces an exit.
      exit_s = (state_q == ST_GRANT) &&
               (!core_valid_s || (xfer_s && (cnt_q == cnt_last_lp)));
      if (gidx_q == idx_last_lp) begin
         ptr_d = '0;
      end else begin
         ptr_d = gidx_q + idx_w_lp'(1);
      end
   end

   assign bus.core_valid_o = core_valid_s;
   assign bus.core_data_o  = core_data_s;
   assign bus.req_ready_o  = req_ready_s;
   assign bus.grant_o      = grant_q;
   assign bus.busy_o       = busy_q;

   // Arbiter FSM with registered grant/busy; reset overrides everything.
   always_ff @(posedge main_clk_i) begin
      if (main_rst_i) begin
         state_q <= ST_IDLE;
         gidx_q  <= '0;
         ptr_q   <= '0;
         cnt_q   <= '0;
         grant_q <= '0;
         busy_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (found_s) begin
                  state_q <= ST_GRANT;
                  gidx_q  <= sel_idx_s;
                  cnt_q   <= '0;
                  grant_q <= sel_onehot_s;
                  busy_q  <= 1'b1;
               end
            end
            ST_GRANT: begin
               if (exit_s) begin
                  state_q <= ST_IDLE;
                  ptr_q   <= ptr_d;
                  cnt_q   <= '0;
                  grant_q <= '0;
                  busy_q  <= 1'b0;
               end else if (xfer_s) begin
                  cnt_q <= cnt_q + cnt_w_lp'(1);
               end
            end
            default: begin
               state_q <= ST_IDLE;
               cnt_q   <= '0;
               grant_q <= '0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_top_core_arb.sv
// ---------------------------------------------------------------------------
// tb_top_core_arb
// Directed bench for top_core_arb. dut_a (burst_p=4) is driven from a table
// of per-cycle {reset, valid, core_ready, expected grant} rows; the other
// outputs are derived from the expected grant and the applied inputs.
// dut_b (burst_p=1) runs a hand-written alternating-grant sequence.
// Inputs change 1 ns after the rising edge, outputs are sampled on the
// falling edge.
// ---------------------------------------------------------------------------
module tb_top_core_arb;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_a;
   logic rst_b;

   top_core_arb_if #(.width_p(8), .req_num_p(4)) bus_a ();
   top_core_arb_if #(.width_p(8), .req_num_p(4)) bus_b ();

   top_core_arb #(.width_p(8), .req_num_p(4), .burst_p(4)) dut_a (
      .main_clk_i (clk),
      .main_rst_i (rst_a),
      .bus        (bus_a.master)
   );

   top_core_arb #(.width_p(8), .req_num_p(4), .burst_p(1)) dut_b (
      .main_clk_i (clk),
      .main_rst_i (rst_b),
      .bus        (bus_b.master)
   );

   typedef struct {
      logic       rst;
      logic [3:0] valid;
      logic       cready;
      logic [3:0] grant;
   } vec_t;

   vec_t vecs[$];
   int   checks = 0;
   int   errors = 0;

   // requester n presents 8'h11*(n+1)
   localparam logic [31:0] data_c = 32'h44332211;

   task automatic check(input string name, input int row,
                        input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
      end
   endtask

   function automatic logic [7:0] exp_data(input logic [3:0] g);
      case (g)
         4'b0001: exp_data = 8'h11;
         4'b0010: exp_data = 8'h22;
         4'b0100: exp_data = 8'h33;
         4'b1000: exp_data = 8'h44;
         default: exp_data = 8'h00;
      endcase
   endfunction

   task automatic add(input int n, input logic rst, input logic [3:0] valid,
                      input logic cready, input logic [3:0] grant);
      vec_t v;
      v.rst = rst; v.valid = valid; v.cready = cready; v.grant = grant;
      for (int i = 0; i < n; i++) vecs.push_back(v);
   endtask

   task automatic check_outputs(input string tag, input int row, input logic [3:0] valid,
                                input logic cready, input logic [3:0] g,
                                input logic [3:0] act_grant, input logic act_busy,
                                input logic act_cvalid, input logic [7:0] act_cdata,
                                input logic [3:0] act_rready);
      check({tag, ".grant"},      row, 32'(act_grant),  32'(g));
      check({tag, ".busy"},       row, 32'(act_busy),   32'(|g));
      check({tag, ".core_valid"}, row, 32'(act_cvalid), 32'(|(g & valid)));
      check({tag, ".core_data"},  row, 32'(act_cdata),  32'(exp_data(g)));
      check({tag, ".req_ready"},  row, 32'(act_rready), 32'(g & {4{cready}}));
   endtask

   logic [3:0] seq_b [8];

   initial begin
      rst_a = 1'b1;
      rst_b = 1'b1;
      bus_a.req_valid_i  = 4'b0000;
      bus_a.req_data_i   = data_c;
      bus_a.core_ready_i = 1'b0;
      bus_b.req_valid_i  = 4'b0000;
      bus_b.req_data_i   = data_c;
      bus_b.core_ready_i = 1'b0;

      // rst, valid, core_ready, expected grant
      add(1, 1'b1, 4'b0001, 1'b1, 4'b0000); // reset cycle: nothing granted
      add(1, 1'b0, 4'b0001, 1'b1, 4'b0000); // idle, arbitrating
      add(4, 1'b0, 4'b0001, 1'b1, 4'b0001); // 4 transfers
      add(1, 1'b0, 4'b0001, 1'b1, 4'b0000); // one idle cycle
      add(4, 1'b0, 4'b1111, 1'b1, 4'b0001); // re-grant 0, then all request
      add(1, 1'b0, 4'b1111, 1'b1, 4'b0000);
      add(4, 1'b0, 4'b1111, 1'b1, 4'b0010);
      add(1, 1'b0, 4'b1111, 1'b1, 4'b0000);
      add(4, 1'b0, 4'b1111, 1'b1, 4'b0100);
      add(1, 1'b0, 4'b1111, 1'b1, 4'b0000);
      add(4, 1'b0, 4'b1111, 1'b1, 4'b1000);
      add(1, 1'b0, 4'b1111, 1'b1, 4'b0000); // ptr wraps to 0
      add(1, 1'b0, 4'b1111, 1'b1, 4'b0001); // transfer 1
      add(5, 1'b0, 4'b1111, 1'b0, 4'b0001); // 5-cycle stall holds grant
      add(3, 1'b0, 4'b1111, 1'b1, 4'b0001); // remaining 3 transfers
      add(1, 1'b0, 4'b0100, 1'b1, 4'b0000); // idle, ptr=1 -> picks 2
      add(2, 1'b0, 4'b0100, 1'b1, 4'b0100); // 2 transfers
      add(1, 1'b0, 4'b1000, 1'b1, 4'b0100); // owner drops valid -> exit
      add(1, 1'b0, 4'b1000, 1'b1, 4'b0000); // ptr=3 -> picks 3
      add(2, 1'b0, 4'b1000, 1'b1, 4'b1000); // cnt reaches 2
      add(1, 1'b1, 4'b1111, 1'b1, 4'b1000); // reset mid-burst
      add(1, 1'b0, 4'b1111, 1'b1, 4'b0000); // idle after reset
      add(1, 1'b0, 4'b1111, 1'b1, 4'b0001); // restarts from index 0
      add(1, 1'b0, 4'b1101, 1'b1, 4'b0001); // non-owner changes ignored
      add(1, 1'b0, 4'b0011, 1'b1, 4'b0001);
      add(1, 1'b0, 4'b1111, 1'b1, 4'b0001); // 4th transfer
      add(1, 1'b0, 4'b1111, 1'b1, 4'b0000);
      add(1, 1'b0, 4'b1111, 1'b1, 4'b0010);

      repeat (2) @(posedge clk);

      for (int i = 0; i < vecs.size(); i++) begin
         @(posedge clk);
         #1;
         rst_a              = vecs[i].rst;
         bus_a.req_valid_i  = vecs[i].valid;
         bus_a.core_ready_i = vecs[i].cready;
         @(negedge clk);
         check_outputs("a", i, vecs[i].valid, vecs[i].cready, vecs[i].grant,
                       bus_a.grant_o, bus_a.busy_o, bus_a.core_valid_o,
                       bus_a.core_data_o, bus_a.req_ready_o);
      end

      // burst_p=1 with requesters 0 and 3: one transfer per grant, alternating
      seq_b[0] = 4'b0000; seq_b[1] = 4'b0001; seq_b[2] = 4'b0000; seq_b[3] = 4'b1000;
      seq_b[4] = 4'b0000; seq_b[5] = 4'b0001; seq_b[6] = 4'b0000; seq_b[7] = 4'b1000;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         #1;
         rst_b              = 1'b0;
         bus_b.req_valid_i  = 4'b1001;
         bus_b.core_ready_i = 1'b1;
         @(negedge clk);
         check_outputs("b", i, 4'b1001, 1'b1, seq_b[i],
                       bus_b.grant_o, bus_b.busy_o, bus_b.core_valid_o,
                       bus_b.core_data_o, bus_b.req_ready_o);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/top_core_arb.md
TOP_CORE_ARB -- requirements
Module: top_core_arb

Interface
REQ-001 Parameter width_p, default 8: data width of every requester port and of the core port.
REQ-002 Parameter req_num_p, default 4: number of requesters; legal range 2..8.
REQ-003 Parameter burst_p, default 4: maximum transfers per grant; legal range 1..15.
REQ-004 main_clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-005 main_rst_i  input  1  synchronous, active-high reset.
REQ-006 req_valid_i  input  req_num_p  per-requester data-valid.
REQ-007 req_data_i  input  req_num_p*width_p  requester n data at bits [n*width_p +: width_p].
REQ-008 req_ready_o  output  req_num_p  per-requester accept.
REQ-009 core_valid_o  output  1  data valid towards the core data_i port.
REQ-010 core_data_o  output  width_p  data towards the core data_i port.
REQ-011 core_ready_i  input  1  core accepts data.
REQ-012 grant_o  output  req_num_p  one-hot current owner; all-zero when idle.
REQ-013 busy_o  output  1  high while in state GRANT.

Function
REQ-014 FSM has two states, IDLE and GRANT. State, grant index, round-robin pointer ptr (0..req_num_p-1) and burst counter cnt (0..burst_p) are registers.
REQ-015 IDLE: if any req_valid_i bit is set, select the first set bit at index ptr, ptr+1, ... with wrap from req_num_p-1 to 0; next cycle is GRANT with grant_o one-hot at that index and cnt=0.
REQ-016 IDLE: grant_o=0, busy_o=0, req_ready_o=0, core_valid_o=0, core_data_o=0.
REQ-017 GRANT, owner g: core_valid_o=req_valid_i[g], core_data_o=slice g of req_data_i, req_ready_o[g]=core_ready_i, all other req_ready_o bits 0 (combinational, same cycle).
REQ-018 Transfer = core_valid_o & core_ready_i in GRANT; each transfer increments cnt.
REQ-019 GRANT exits to IDLE at the next edge when either (a) a transfer occurs with cnt=burst_p-1, or (b) req_valid_i[g]=0. On exit ptr <= (g+1) mod req_num_p and cnt <= 0.
REQ-020 Arbitration latency: 1 cycle from IDLE with a valid request to grant_o asserted; a transfer in that first GRANT cycle is legal.
REQ-021 Re-arbitration costs exactly one IDLE cycle between consecutive grants, including when other requesters are waiting at exit.
REQ-022 Core stall (core_ready_i=0) holds state, cnt and grant unchanged; a stall never forces an exit.
REQ-023 Non-owner req_valid_i changes during GRANT have no effect on grant, cnt or outputs.
REQ-024 req_num_p=... width: ptr and grant index need ceil(log2(req_num_p)) bits (min 1); ptr wrap uses explicit compare, not power-of-two truncation.
REQ-025 burst_p=1: every transfer ends the grant (strict per-word round robin).

Reset
REQ-026 main_rst_i high at an edge: state=IDLE, ptr=0, cnt=0, grant=0; takes priority over every other event, including mid-burst and in-flight transfers.
REQ-027 While state=IDLE after reset all outputs are 0 per REQ-016; no request is granted in the cycle reset is high.

Verification
REQ-028 Reset, then req_valid_i=4'b0001 continuous, core_ready_i=1, burst_p=4 -> grant_o=0001 one cycle later, 4 transfers, 1 idle cycle, re-grant of 0001.
REQ-029 req_valid_i=4'b1111 continuous, core_ready_i=1 -> grant order 0001,0010,0100,1000,0001, each 4 transfers, one idle cycle between.
REQ-030 Owner 2 drops valid after 2 transfers -> exit at next edge, ptr=3, next grant 1000 if requester 3 valid else wraps to 0.
REQ-031 Grant held, core_ready_i=0 for 5 cycles -> grant_o, cnt unchanged, req_ready_o=0; resume completes remaining transfers.
REQ-032 main_rst_i asserted during GRANT with cnt=2 -> next cycle grant_o=0, busy_o=0, core_valid_o=0; next grant starts from index 0.
REQ-033 burst_p=1, req_valid_i=4'b1001 -> grants alternate 0001,1000 with one transfer each.
